pixel_dot_engine: RTL

//   Sits directly downstream of pic_ram. On start, scans all 784 pixel addresses
//   of a 28x28 image in order and drives the shared address to pic_ram and the

---
 rtl/pixel_dot_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pixel_dot_engine.sv
// Scans a 28x28 image through pic_ram and the weight ROM and accumulates
// pixel*weight into one signed neuron score with a one-cycle done pulse.
module pixel_dot_engine #(
    parameter int N_PIX  = 784,
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic [WGT_W-1:0]  wgt_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    localparam int                PROD_W   = PIX_W + WGT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [ACC_W-1:0]          result_q, result_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    logic                      rdVld_q;
    logic                      dataVld_q;
    logic                      prodVld_q;
    logic [PIX_W-1:0]          pix_q;
    logic signed [WGT_W-1:0]   wgt_q;
    logic signed [PROD_W-1:0]  prod_q;

    logic                      issueVld;
    logic                      clearAcc;
    logic signed [PROD_W-1:0]  prodFull;
    logic signed [ACC_W-1:0]   prodExt;

    assign issueVld = (state_q == RUN);
    assign prodFull = $signed({1'b0, pix_q}) * wgt_q;
    assign prodExt  = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // FIN is entered on the edge that performs the final accumulate, so the
    // score, done pulse and busy release are all registered on the edge leaving it.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        clearAcc = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    clearAcc = 1'b1;
                end
            end
            RUN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (prodVld_q && !dataVld_q && !rdVld_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                addr_d   = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (clearAcc) begin
            acc_d = '0;
        end else if (prodVld_q) begin
            acc_d = acc_q + prodExt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            acc_q    <= acc_d;
        end
    end

    // Valid bits travel alongside the data so alignment never depends on addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdVld_q   <= 1'b0;
            dataVld_q <= 1'b0;
            prodVld_q <= 1'b0;
            pix_q     <= '0;
            wgt_q     <= '0;
            prod_q    <= '0;
        end else begin
            rdVld_q   <= issueVld;
            dataVld_q <= rdVld_q;
            prodVld_q <= dataVld_q;
            pix_q     <= pix_data;
            wgt_q     <= $signed(wgt_data);
            prod_q    <= prodFull;
        end
    end

    assign addr   = addr_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
